// File: rtl/sha256_compress_if.sv
// sha256_compress_if -- handshake/data bundle for the SHA-256 compression engine.
//
// Signals (named from the engine's point of view):
//   start_in        begin one 512-bit block (honoured only when the engine is idle)
//   first_block_in  sampled with start_in: 1 = load IV into H, 0 = chain current H
//   w_valid_in      W word present on w_in
//   w_in            message schedule word W_t
//   is224_in        (SHA224_MODE_EN builds only) select the SHA-224 IV, sampled
//                   with start_in && first_block_in
//   busy_out        engine not idle
//   dout_valid      one-cycle pulse, digest_out final for the block
//   digest_out      {H0..H7}, H0 in [255:224]
//   o_FSM_state     current state encoding
//
// Modports: master drives the request side (upstream / bench), slave is the engine.
// Optional feature macro: SHA224_MODE_EN.
interface sha256_compress_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_in;
   logic                  first_block_in;
   logic                  w_valid_in;
   logic [DATA_WIDTH-1:0] w_in;
`ifdef SHA224_MODE_EN
   logic                  is224_in;
`endif
   logic                  busy_out;
   logic                  dout_valid;
   logic [255:0]          digest_out;
   logic [1:0]            o_FSM_state;

`ifdef SHA224_MODE_EN
   modport master (
      output start_in, first_block_in, w_valid_in, w_in, is224_in,
      input  busy_out, dout_valid, digest_out, o_FSM_state
   );
   modport slave (
      input  start_in, first_block_in, w_valid_in, w_in, is224_in,
      output busy_out, dout_valid, digest_out, o_FSM_state
   );
`else
   modport master (
      output start_in, first_block_in, w_valid_in, w_in,
      input  busy_out, dout_valid, digest_out, o_FSM_state
   );
   modport slave (
      input  start_in, first_block_in, w_valid_in, w_in,
      output busy_out, dout_valid, digest_out, o_FSM_state
   );
`endif
endinterface

// File: rtl/sha256_compress.sv
// sha256_compress -- SHA-256 compression engine.
//
// Consumes W0..W63 (one word per accepted cycle) from the message-expansion
// stage, runs 64 rounds over a..h with an internal K ROM, folds the result into
// the chaining hash H0..H7 and presents the 256-bit digest. Multi-block
// messages chain through H unless first_block_in reloads the IV.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  sha256_compress_if.slave (see interface file for signal list)
//
// FSM: IDLE(00) -> ROUND(01) -> UPDATE(10) -> DONE(11) -> IDLE.
// Optional feature macro: SHA224_MODE_EN (SHA-224 IV and truncated digest).
module sha256_compress (
   input  logic              clk,
   input  logic              rst,
   sha256_compress_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ROUND  = 2'b01,
      UPDATE = 2'b10,
      DONE   = 2'b11
   } state_t;

   // Word 7 is the most significant word, so a packed vector reads {H0..H7}
   // and the working set reads {a..h}: a=[7] b=[6] c=[5] d=[4] e=[3] f=[2] g=[1] h=[0].
   localparam logic [7:0][31:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_MODE_EN
   localparam logic [7:0][31:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   state_t            state;
   logic [5:0]        round_r;
   logic [7:0][31:0]  wv;        // a..h
   logic [7:0][31:0]  h_r;       // H0..H7
   logic [255:0]      digest_r;
   logic              dout_valid_r;
`ifdef SHA224_MODE_EN
   logic              mode224;   // persists across chained blocks of one message
`endif

   logic [31:0]       t1, t2;
   logic [7:0][31:0]  wv_next;
   logic [7:0][31:0]  h_next;
   logic [7:0][31:0]  iv_sel;

   always_comb begin
      t1 = wv[0] + bsig1(wv[3]) + ((wv[3] & wv[2]) ^ (~wv[3] & wv[1]))
         + K_ROM[round_r] + bus.w_in;
      t2 = bsig0(wv[7]) + ((wv[7] & wv[6]) ^ (wv[7] & wv[5]) ^ (wv[6] & wv[5]));
      wv_next = {t1 + t2, wv[7], wv[6], wv[5], wv[4] + t1, wv[3], wv[2], wv[1]};
      h_next = h_r;
      for (int i = 0; i < 8; i++) h_next[i] = h_r[i] + wv[i];
   end

`ifdef SHA224_MODE_EN
   assign iv_sel = bus.is224_in ? IV224 : IV256;
`else
   assign iv_sel = IV256;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         round_r      <= 6'd0;
         wv           <= '0;
         h_r          <= '0;
         digest_r     <= '0;
         dout_valid_r <= 1'b0;
`ifdef SHA224_MODE_EN
         mode224      <= 1'b0;
`endif
      end else begin
         dout_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_in) begin
                  if (bus.first_block_in) begin
                     h_r <= iv_sel;
                     wv  <= iv_sel;
`ifdef SHA224_MODE_EN
                     mode224 <= bus.is224_in;
`endif
                  end else begin
                     wv <= h_r;
                  end
                  round_r <= 6'd0;
                  state   <= ROUND;
               end
            end
            ROUND: begin
               // w_valid_in low is a full stall: nothing moves.
               if (bus.w_valid_in) begin
                  wv      <= wv_next;
                  round_r <= round_r + 6'd1;
                  if (round_r == 6'd63) state <= UPDATE;
               end
            end
            UPDATE: begin
               h_r <= h_next;
`ifdef SHA224_MODE_EN
               // H7 is still kept whole in h_r so later blocks chain correctly.
               digest_r <= mode224 ? {h_next[7:1], 32'h0} : h_next;
`else
               digest_r <= h_next;
`endif
               dout_valid_r <= 1'b1;
               state        <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy_out    = (state != IDLE);
   assign bus.dout_valid  = dout_valid_r;
   assign bus.digest_out  = digest_r;
   assign bus.o_FSM_state = state;

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress -- randomized self-checking bench for sha256_compress.
// Reference: a plain-array SHA-256 block model (schedule expansion + 64 rounds)
// plus known-answer digests. Also exercises the SHA224_MODE_EN build when defined.
module tb_sha256_compress;

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] TWO_DIG =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk;
   logic rst;
   sha256_compress_if #(.DATA_WIDTH(32)) bus ();

   sha256_compress dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0]  msg [16];
   logic [31:0]  ws  [64];
   logic [255:0] model_h;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Expand the 16-word block into the full schedule.
   task automatic build_sched();
      for (int t = 0; t < 16; t++) ws[t] = msg[t];
      for (int t = 16; t < 64; t++)
         ws[t] = (rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
               + (rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
   endtask

   // One full compression of ws[] starting from chaining value hin.
   function automatic logic [255:0] ref_block(input logic [255:0] hin);
      logic [31:0]  v  [8];
      logic [31:0]  hw [8];
      logic [31:0]  t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         hw[i] = hin[255-32*i -: 32];
         v[i]  = hw[i];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ws[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      r = '0;
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hw[i] + v[i];
      return r;
   endfunction

   task automatic load_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      build_sched();
   endtask

   // Stream one block. abort_at<64 asserts rst when that many words are in.
   // inject pulses start_in mid-ROUND on a stall cycle.
   task automatic run_block(input bit first, input int gap_pct, input int abort_at,
                            input bit inject, output logic [255:0] dig);
      int t, cyc;
      bit vld, injected;
      t = 0; cyc = 0; injected = 0; dig = '0;
      @(negedge clk);
      bus.start_in = 1'b1; bus.first_block_in = first; bus.w_valid_in = 1'b0;
      @(posedge clk); #1;
      chk("start_state", 256'(bus.o_FSM_state), 256'(2'b01));
      chk("start_busy", 256'(bus.busy_out), 256'(1));
      while (t < 64 && cyc < 3000) begin
         @(negedge clk);
         bus.start_in = 1'b0;
         cyc++;
         if (t == abort_at) begin
            rst = 1'b1; bus.w_valid_in = 1'b1; bus.w_in = ws[t];
            @(posedge clk); #1;
            chk("abort_state", 256'(bus.o_FSM_state), 256'(2'b00));
            chk("abort_busy", 256'(bus.busy_out), 256'(0));
            chk("abort_dv", 256'(bus.dout_valid), 256'(0));
            chk("abort_digest", bus.digest_out, 256'h0);
            @(negedge clk);
            rst = 1'b0; bus.w_valid_in = 1'b0;
            @(posedge clk); #1;
            chk("abort_dv2", 256'(bus.dout_valid), 256'(0));
            chk("abort_state2", 256'(bus.o_FSM_state), 256'(2'b00));
            return;
         end
         if (inject && !injected && t == 10) begin
            bus.start_in = 1'b1; bus.first_block_in = 1'b1; bus.w_valid_in = 1'b0;
            injected = 1'b1;
            @(posedge clk); #1;
            chk("inject_state", 256'(bus.o_FSM_state), 256'(2'b01));
            continue;
         end
         vld = ($urandom_range(99) >= gap_pct);
         bus.w_valid_in = vld;
         bus.w_in = vld ? ws[t] : $urandom();
         @(posedge clk); #1;
         if (vld) t++;
      end
      if (t < 64) begin
         chk("timeout_words", 256'(t), 256'(64));
         return;
      end
      // Just past the edge that accepted W63.
      chk("w63_state", 256'(bus.o_FSM_state), 256'(2'b10));
      chk("w63_dv", 256'(bus.dout_valid), 256'(0));
      @(negedge clk);
      bus.w_valid_in = 1'b0; bus.w_in = $urandom();
      @(posedge clk); #1;
      chk("done_state", 256'(bus.o_FSM_state), 256'(2'b11));
      chk("done_dv", 256'(bus.dout_valid), 256'(1));
      dig = bus.digest_out;
      @(posedge clk); #1;
      chk("idle_state", 256'(bus.o_FSM_state), 256'(2'b00));
      chk("idle_dv", 256'(bus.dout_valid), 256'(0));
      chk("idle_busy", 256'(bus.busy_out), 256'(0));
      chk("digest_held", bus.digest_out, dig);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [255:0] dig, exp1, exp2;
      bit first;
      rst = 1'b1;
      bus.start_in = 1'b0; bus.first_block_in = 1'b0;
      bus.w_valid_in = 1'b0; bus.w_in = 32'h0;
`ifdef SHA224_MODE_EN
      bus.is224_in = 1'b0;
`endif
      model_h = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 256'(bus.o_FSM_state), 256'(2'b00));
      chk("rst_busy", 256'(bus.busy_out), 256'(0));
      chk("rst_dv", 256'(bus.dout_valid), 256'(0));
      chk("rst_digest", bus.digest_out, 256'h0);

      // rst and start_in together: rst wins.
      @(negedge clk);
      bus.start_in = 1'b1; bus.first_block_in = 1'b1;
      @(posedge clk); #1;
      chk("rst_vs_start", 256'(bus.o_FSM_state), 256'(2'b00));
      @(negedge clk);
      bus.start_in = 1'b0; rst = 1'b0;

      // "abc", gapless
      load_abc();
      exp1 = ref_block(IV256);
      run_block(1'b1, 0, 99, 1'b0, dig);
      chk("abc_kat", dig, ABC_DIG);
      chk("abc_model", dig, exp1);
      model_h = exp1;

      // w_valid_in in IDLE must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.w_valid_in = 1'b1; bus.w_in = $urandom();
      end
      @(posedge clk); #1;
      chk("idle_wvalid_state", 256'(bus.o_FSM_state), 256'(2'b00));
      chk("idle_wvalid_digest", bus.digest_out, ABC_DIG);
      @(negedge clk);
      bus.w_valid_in = 1'b0;

      // Two-block 448-bit message.
      msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      build_sched();
      exp1 = ref_block(IV256);
      run_block(1'b1, 0, 99, 1'b0, dig);
      chk("two_blk1", dig, exp1);
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[15] = 32'h000001c0;
      build_sched();
      exp2 = ref_block(exp1);
      run_block(1'b0, 0, 99, 1'b0, dig);
      chk("two_blk2_kat", dig, TWO_DIG);
      chk("two_blk2_model", dig, exp2);

      // "abc" with ~30% stalls and a start_in pulse mid-ROUND.
      load_abc();
      run_block(1'b1, 30, 99, 1'b1, dig);
      chk("abc_gaps", dig, ABC_DIG);

      // Abort at round 30, then a fresh run.
      run_block(1'b1, 0, 30, 1'b0, dig);
      run_block(1'b1, 10, 99, 1'b0, dig);
      chk("abc_after_abort", dig, ABC_DIG);

      // Random blocks with random chaining and stalls.
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 16; i++) msg[i] = $urandom();
         build_sched();
         first = (b == 0) || ($urandom_range(2) == 0);
         exp1 = ref_block(first ? IV256 : model_h);
         model_h = exp1;
         run_block(first, 20, 99, 1'b0, dig);
         chk($sformatf("rand_blk%0d", b), dig, exp1);
      end

`ifdef SHA224_MODE_EN
      load_abc();
      bus.is224_in = 1'b1;
      exp1 = ref_block(IV224);
      run_block(1'b1, 0, 99, 1'b0, dig);
      bus.is224_in = 1'b0;
      chk("sha224_model", dig, {exp1[255:32], 32'h0});
      chk("sha224_kat", dig,
          {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0});
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
